// File: rtl/bsg_scan_pipelined_pkg.sv
// Shared types and bit-level helpers for the pipelined prefix scan.
package bsg_scan_pipelined_pkg;

    typedef enum logic [1:0] {
        SCAN_XOR  = 2'b00,
        SCAN_AND  = 2'b01,
        SCAN_OR   = 2'b10,
        SCAN_PASS = 2'b11
    } scan_op_e;

    // Value that leaves the other operand unchanged; pass-through never combines, so 0 is fine.
    function automatic logic scan_identity(scan_op_e op);
        return (op == SCAN_AND);
    endfunction

    // Pass-through keeps the local bit and ignores the neighbour.
    function automatic logic scan_combine(scan_op_e op, logic a, logic b);
        logic r;
        case (op)
            SCAN_XOR: r = a ^ b;
            SCAN_AND: r = a & b;
            SCAN_OR:  r = a | b;
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bsg_scan_pipelined_if.sv
// Producer/consumer bundle for bsg_scan_pipelined: valid/ready input, valid/yumi output.
// BSG_SCAN_PIPELINED_EXCL_EN adds the excl_i request bit.
interface bsg_scan_pipelined_if #(
    parameter int unsigned width_p = 16
);
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] data_i;
    logic [1:0]         op_i;
    logic               lo_to_hi_i;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
`ifdef BSG_SCAN_PIPELINED_EXCL_EN
    logic               excl_i;

    modport master (
        output v_i, data_i, op_i, lo_to_hi_i, excl_i, yumi_i,
        input  ready_o, v_o, data_o
    );

    modport slave (
        input  v_i, data_i, op_i, lo_to_hi_i, excl_i, yumi_i,
        output ready_o, v_o, data_o
    );
`else
    modport master (
        output v_i, data_i, op_i, lo_to_hi_i, yumi_i,
        input  ready_o, v_o, data_o
    );

    modport slave (
        input  v_i, data_i, op_i, lo_to_hi_i, yumi_i,
        output ready_o, v_o, data_o
    );
`endif
endinterface

// File: rtl/bsg_scan_pipelined_level.sv
// One prefix level at neighbour distance dist_p, followed by its pipeline register.
// The register holds while load_i is low, which is how a stall propagates through it.
module bsg_scan_pipelined_level
    import bsg_scan_pipelined_pkg::*;
#(
    parameter int unsigned width_p = 16,
    parameter int unsigned dist_p  = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  scan_op_e           op_i,
    input  logic               dir_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output scan_op_e           op_o,
    output logic               dir_o
);

    logic               ident;
    logic [width_p-1:0] level_data;

    assign ident = scan_identity(op_i);

    // Neighbours that fall off either end of the vector read as the identity.
    for (genvar j = 0; j < width_p; j++) begin : g_bit
        logic nbr_hi;
        logic nbr_lo;

        if (j + dist_p < width_p) begin : g_hi
            assign nbr_hi = data_i[j+dist_p];
        end else begin : g_hi_ident
            assign nbr_hi = ident;
        end

        if (j >= dist_p) begin : g_lo
            assign nbr_lo = data_i[j-dist_p];
        end else begin : g_lo_ident
            assign nbr_lo = ident;
        end

        assign level_data[j] = scan_combine(op_i, data_i[j], dir_i ? nbr_lo : nbr_hi);
    end

    // Stage register: captures a new slot on load, payload only when the slot is valid.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_o    <= 1'b0;
            data_o <= '0;
            op_o   <= SCAN_XOR;
            dir_o  <= 1'b0;
        end else if (load_i) begin
            v_o <= v_i;
            if (v_i) begin
                data_o <= level_data;
                op_o   <= op_i;
                dir_o  <= dir_i;
            end
        end
    end

endmodule

// File: rtl/bsg_scan_pipelined.sv
// Pipelined Kogge-Stone prefix scan: $clog2(width_p) levels, one register per level.
// Optional macro BSG_SCAN_PIPELINED_EXCL_EN enables the exclusive-scan request bit excl_i.
module bsg_scan_pipelined
    import bsg_scan_pipelined_pkg::*;
#(
    parameter int unsigned width_p = 16
) (
    input logic                   clk_i,
    input logic                   reset_i,
    bsg_scan_pipelined_if.slave   io
);

    localparam int unsigned els_lp = $clog2(width_p);

    // Index s is the input of level s; index els_lp is the last register.
    logic [els_lp:0]              chain_v;
    logic [els_lp:0][width_p-1:0] chain_data;
    scan_op_e                     chain_op [els_lp+1];
    logic [els_lp:0]              chain_dir;
    logic [els_lp:0]              adv;
    logic [width_p-1:0]           in_data;
    logic                         unused_tail;

`ifdef BSG_SCAN_PIPELINED_EXCL_EN
    logic in_ident;
    assign in_ident = scan_identity(scan_op_e'(io.op_i));

    // Exclusive scan: shift one place against the scan direction, vacated bit takes the identity.
    always_comb begin
        in_data = io.data_i;
        if (io.excl_i) begin
            if (io.lo_to_hi_i) begin
                in_data = {io.data_i[width_p-2:0], in_ident};
            end else begin
                in_data = {in_ident, io.data_i[width_p-1:1]};
            end
        end
    end
`else
    assign in_data = io.data_i;
`endif

    assign chain_v[0]    = io.v_i;
    assign chain_data[0] = in_data;
    assign chain_op[0]   = scan_op_e'(io.op_i);
    assign chain_dir[0]  = io.lo_to_hi_i;

    // Advance chain: a stage loads when empty or when the stage after it loads.
    always_comb begin
        adv         = '0;
        adv[els_lp] = io.yumi_i;
        for (int s = int'(els_lp) - 1; s >= 0; s--) begin
            adv[s] = !chain_v[s+1] | adv[s+1];
        end
    end

    for (genvar s = 0; s < els_lp; s++) begin : g_level
        bsg_scan_pipelined_level #(
            .width_p (width_p),
            .dist_p  (2 ** s)
        ) u_level (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .load_i  (adv[s]),
            .v_i     (chain_v[s]),
            .data_i  (chain_data[s]),
            .op_i    (chain_op[s]),
            .dir_i   (chain_dir[s]),
            .v_o     (chain_v[s+1]),
            .data_o  (chain_data[s+1]),
            .op_o    (chain_op[s+1]),
            .dir_o   (chain_dir[s+1])
        );
    end

    assign io.ready_o = adv[0] & ~reset_i;
    assign io.v_o     = chain_v[els_lp];
    assign io.data_o  = chain_data[els_lp];

    // The final op/dir are not needed once the last level has been applied.
    assign unused_tail = ^{chain_op[els_lp], chain_dir[els_lp]};

    // The consumer may only take a result that is being offered.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(io.yumi_i && !io.v_o));
        end
    end

endmodule

// File: tb/tb_bsg_scan_pipelined.sv
// Scoreboard bench for bsg_scan_pipelined at width 16.
module tb_bsg_scan_pipelined;

    localparam int W   = 16;
    localparam int LAT = 4;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic yumi_en = 1'b0;

    bsg_scan_pipelined_if #(.width_p(W)) io ();

    bsg_scan_pipelined #(.width_p(W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .io      (io)
    );

    always #5 clk = ~clk;

    assign io.yumi_i = yumi_en & io.v_o;

    typedef struct {
        logic [W-1:0] exp;
        int           acc;
        bit           lat;
    } sb_t;

    sb_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic op_ident(input logic [1:0] op);
        return op == 2'b01;
    endfunction

    function automatic logic op_apply(input logic [1:0] op, input logic a, input logic b);
        case (op)
            2'b00:   return a ^ b;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a;
        endcase
    endfunction

    // Direct definition: o[k] folds every bit in the scanned range.
    function automatic logic [W-1:0] ref_scan(input logic [W-1:0] d, input logic [1:0] op,
                                              input logic l2h, input logic ex);
        logic [W-1:0] s;
        logic [W-1:0] o;
        logic         id;
        logic         acc;
        id = op_ident(op);
        s  = d;
        if (ex) begin
            if (l2h) s = {d[W-2:0], id};
            else     s = {id, d[W-1:1]};
        end
        if (op == 2'b11) return s;
        for (int k = 0; k < W; k++) begin
            acc = id;
            for (int j = 0; j < W; j++) begin
                if (l2h ? (j <= k) : (j >= k)) acc = op_apply(op, acc, s[j]);
            end
            o[k] = acc;
        end
        return o;
    endfunction

    // Monitor: output checks, latency and stall-stability, away from the clock edge.
    initial begin
        logic [W-1:0] held;
        bit           stalled;
        sb_t          e;
        stalled = 0;
        held    = '0;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check_eq("stall_hold_data", io.data_o, held);
                    check_eq("stall_hold_v", io.v_o, 1);
                end
                if (io.v_o && io.yumi_i) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_v_o", io.v_o, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("data_o", io.data_o, e.exp);
                        if (e.lat) check_eq("latency", cyc - e.acc, LAT);
                    end
                end
                stalled = io.v_o && !io.yumi_i;
                held    = io.data_o;
            end
        end
    end

    // Called just after a negedge; returns just after the negedge that follows the accept.
    task automatic send(input logic [W-1:0] d, input logic [1:0] op, input logic l2h,
                        input logic ex, input logic [W-1:0] expv, input bit lat,
                        output int waited);
        io.v_i        = 1'b1;
        io.data_i     = d;
        io.op_i       = op;
        io.lo_to_hi_i = l2h;
`ifdef BSG_SCAN_PIPELINED_EXCL_EN
        io.excl_i     = ex;
`endif
        waited = 0;
        #1;
        while (!io.ready_o && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!io.ready_o) check_eq("accept_timeout", io.ready_o, 1);
        else exp_q.push_back('{exp: expv, acc: cyc, lat: lat});
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        io.v_i = 1'b0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           w;
        int           acc_n;
        logic [W-1:0] d;
        logic [1:0]   op;
        logic         l2h;
        logic         ex;

        io.v_i        = 1'b0;
        io.data_i     = '0;
        io.op_i       = 2'b00;
        io.lo_to_hi_i = 1'b0;
`ifdef BSG_SCAN_PIPELINED_EXCL_EN
        io.excl_i     = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_v_o", io.v_o, 0);
        check_eq("reset_data_o", io.data_o, 0);
        check_eq("reset_ready_o", io.ready_o, 0);
        @(negedge clk);
        reset   = 1'b0;
        yumi_en = 1'b1;

        // Directed vectors with exact latency
        send(16'h0001, 2'b00, 1'b0, 1'b0, 16'h0001, 1, w);
        drain();
        send(16'h8000, 2'b00, 1'b0, 1'b0, 16'hFFFF, 1, w);
        drain();
        send(16'h0010, 2'b10, 1'b1, 1'b0, 16'hFFF0, 1, w);
        send(16'hFF0F, 2'b01, 1'b0, 1'b0, 16'hFF00, 1, w);
        send(16'hA5C3, 2'b11, 1'b0, 1'b0, 16'hA5C3, 1, w);
        send(16'h8001, 2'b00, 1'b0, 1'b0, 16'hFFFE, 1, w);
`ifdef BSG_SCAN_PIPELINED_EXCL_EN
        send(16'h8001, 2'b00, 1'b0, 1'b1, 16'h7FFF, 1, w);
        send(16'h8001, 2'b00, 1'b1, 1'b1, ref_scan(16'h8001, 2'b00, 1'b1, 1'b1), 1, w);
`endif
        drain();

        // Back-to-back random stream: every cycle accepted, every result at fixed latency
        for (int i = 0; i < 20; i++) begin
            d   = W'($urandom);
            op  = 2'($urandom_range(0, 3));
            l2h = 1'($urandom_range(0, 1));
`ifdef BSG_SCAN_PIPELINED_EXCL_EN
            ex  = 1'($urandom_range(0, 1));
`else
            ex  = 1'b0;
`endif
            send(d, op, l2h, ex, ref_scan(d, op, l2h, ex), 1, w);
            check_eq("ready_stream", w, 0);
        end
        drain();

        // Stall: consumer idle for 8 cycles while the producer keeps offering
        yumi_en = 1'b0;
        acc_n   = 0;
        for (int i = 0; i < 8; i++) begin
            d             = W'($urandom);
            op            = 2'($urandom_range(0, 3));
            l2h           = 1'($urandom_range(0, 1));
            io.v_i        = 1'b1;
            io.data_i     = d;
            io.op_i       = op;
            io.lo_to_hi_i = l2h;
`ifdef BSG_SCAN_PIPELINED_EXCL_EN
            io.excl_i     = 1'b0;
`endif
            #1;
            if (io.ready_o) begin
                exp_q.push_back('{exp: ref_scan(d, op, l2h, 1'b0), acc: cyc, lat: 0});
                acc_n++;
            end
            @(negedge clk);
        end
        check_eq("stall_accepts", acc_n, 4);
        #1;
        check_eq("stall_ready_low", io.ready_o, 0);
        io.v_i = 1'b0;
        @(negedge clk);
        yumi_en = 1'b1;
        drain();

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            d = W'($urandom);
            send(d, 2'b00, 1'b1, 1'b0, ref_scan(d, 2'b00, 1'b1, 1'b0), 1, w);
        end
        io.v_i = 1'b0;
        reset  = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        check_eq("midreset_v_o", io.v_o, 0);
        check_eq("midreset_data_o", io.data_o, 0);
        check_eq("midreset_ready_o", io.ready_o, 0);
        @(negedge clk);
        reset = 1'b0;
        d     = 16'h1234;
        send(d, 2'b10, 1'b0, 1'b0, ref_scan(d, 2'b10, 1'b0, 1'b0), 1, w);
        drain();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
